// File: rtl/puf_result_pkg.sv
// Types and constants shared by the NIST result reader and its UART serialiser.
package puf_result_pkg;

    localparam int unsigned DEFAULT_BASE_ADDR = 1;
    localparam int unsigned NUM_NIST_TESTS    = 8;
    localparam int unsigned BYTE_IDX_W        = 4;

    localparam int unsigned FRAME_BITS = 10;
    localparam logic        START_BIT  = 1'b0;
    localparam logic        STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_TX_REQ,
        S_TX_WAIT,
        S_NEXT,
        S_DONE
    } rd_state_e;

endpackage

// File: rtl/puf_result_reader_if.sv
// Control, result-BRAM read port and UART line of the result reader.
interface puf_result_reader_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8
);
    import puf_result_pkg::*;

    logic                  start;
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  uart_tx;
    logic                  busy;
    logic                  done;
    logic [BYTE_IDX_W-1:0] byte_idx;

    modport master (
        input  start,
        input  mem_rdata,
        output mem_en,
        output mem_raddr,
        output uart_tx,
        output busy,
        output done,
        output byte_idx
    );

    modport slave (
        output start,
        output mem_rdata,
        input  mem_en,
        input  mem_raddr,
        input  uart_tx,
        input  busy,
        input  done,
        input  byte_idx
    );

endinterface

// File: rtl/puf_result_reader_uart_tx_byte.sv
// 8N1 UART transmitter: one frame per accepted byte, LSB first, line idles high.
module uart_tx_byte
    import puf_result_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_line
);

    // FRAME_BITS counts start + stop around an 8-bit payload
    localparam int unsigned FRAME_LEN = DATA_WIDTH + FRAME_BITS - 8;
    localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);

    logic [FRAME_LEN-1:0] shift_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bits_q;

    // Bit 0 of the shift register is the line; ones refill from the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '1;
            cnt_q    <= '0;
            bits_q   <= '0;
            tx_ready <= 1'b1;
        end else if (tx_ready) begin
            if (tx_valid) begin
                shift_q  <= {STOP_BIT, tx_data, START_BIT};
                cnt_q    <= '0;
                bits_q   <= '0;
                tx_ready <= 1'b0;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bits_q == BIT_LAST) begin
                tx_ready <= 1'b1;
            end else begin
                bits_q  <= bits_q + BIT_W'(1);
                shift_q <= {1'b1, shift_q[FRAME_LEN-1:1]};
            end
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tx_line = shift_q[0];

endmodule

// File: rtl/puf_result_reader.sv
// Reads NUM_RESULTS pass-count bytes from the result BRAM and sends each over UART.
// Optional RESULT_CHECKSUM_EN appends a modulo-256 sum frame after the last byte.
module puf_result_reader
    import puf_result_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 13,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned NUM_RESULTS  = NUM_NIST_TESTS,
    parameter int unsigned BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input logic                 clk,
    input logic                 rst,
    puf_result_reader_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(NUM_RESULTS - 1);
`ifdef RESULT_CHECKSUM_EN
    localparam logic [BYTE_IDX_W-1:0] CSUM_IDX = BYTE_IDX_W'(NUM_RESULTS);
`endif

    rd_state_e             state_q, state_d;
    logic                  mem_en_q, mem_en_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
`ifdef RESULT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif
    logic                  tx_valid_c;
    logic                  tx_ready;
    logic                  tx_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mem_en_q <= 1'b0;
            raddr_q  <= BASE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            idx_q    <= '0;
            hold_q   <= '0;
`ifdef RESULT_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mem_en_q <= mem_en_d;
            raddr_q  <= raddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
`ifdef RESULT_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Outputs are computed one cycle ahead so they register with the state
    always_comb begin
        state_d    = state_q;
        mem_en_d   = 1'b0;
        raddr_d    = raddr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        hold_d     = hold_q;
        tx_valid_c = 1'b0;
`ifdef RESULT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    raddr_d  = BASE;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    mem_en_d = 1'b1;
                    state_d  = S_RD_ISSUE;
`ifdef RESULT_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                hold_d  = bus.mem_rdata;
                state_d = S_TX_REQ;
`ifdef RESULT_CHECKSUM_EN
                csum_d  = csum_q + bus.mem_rdata;
`endif
            end
            S_TX_REQ: begin
                tx_valid_c = 1'b1;
                if (tx_ready) state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (tx_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
`ifdef RESULT_CHECKSUM_EN
                    hold_d  = csum_q;
                    idx_d   = CSUM_IDX;
                    state_d = S_TX_REQ;
                end else if (idx_q == CSUM_IDX) begin
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    raddr_d = BASE;
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + BYTE_IDX_W'(1);
                    raddr_d  = raddr_q + ADDR_WIDTH'(1);
                    mem_en_d = 1'b1;
                    state_d  = S_RD_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_uart (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid_c),
        .tx_data  (hold_q),
        .tx_ready (tx_ready),
        .tx_line  (tx_line)
    );

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_raddr = raddr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.byte_idx  = idx_q;
    assign bus.uart_tx   = tx_line;

endmodule

// File: tb/tb_puf_result_reader.sv
// Directed bench for puf_result_reader: frame decode, BRAM read sequence, start/reset corner cases.
module tb_puf_result_reader;
    import puf_result_pkg::*;

    localparam int unsigned CPB        = 4;
    localparam int unsigned AW         = 13;
    localparam int unsigned FRAME_CYC  = FRAME_BITS * CPB;
    localparam int unsigned BYTE_CYC   = FRAME_CYC + 5;
    localparam int unsigned CSUM_EXTRA = FRAME_CYC + 3;
`ifdef RESULT_CHECKSUM_EN
    localparam int unsigned CSUM_FRAMES = 1;
`else
    localparam int unsigned CSUM_FRAMES = 0;
`endif

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    logic [7:0] mem [0:8191];

    puf_result_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) if0 ();
    puf_result_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(8)) if1 ();

    puf_result_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(8), .NUM_RESULTS(8), .BASE_ADDR(1), .CLKS_PER_BIT(CPB)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    puf_result_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(8), .NUM_RESULTS(4), .BASE_ADDR(8190), .CLKS_PER_BIT(CPB)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Synchronous-read result BRAM, one cycle latency
    always @(posedge clk) begin
        if (if0.mem_en) if0.mem_rdata <= mem[if0.mem_raddr];
        if (if1.mem_en) if1.mem_rdata <= mem[if1.mem_raddr];
    end

    logic          line_s [2];
    logic          en_s   [2];
    logic          done_s [2];
    logic          busy_s [2];
    logic [AW-1:0] addr_s [2];
    logic [3:0]    idx_s  [2];
    assign line_s[0] = if0.uart_tx;   assign line_s[1] = if1.uart_tx;
    assign en_s[0]   = if0.mem_en;    assign en_s[1]   = if1.mem_en;
    assign done_s[0] = if0.done;      assign done_s[1] = if1.done;
    assign busy_s[0] = if0.busy;      assign busy_s[1] = if1.busy;
    assign addr_s[0] = if0.mem_raddr; assign addr_s[1] = if1.mem_raddr;
    assign idx_s[0]  = if0.byte_idx;  assign idx_s[1]  = if1.byte_idx;

    int            en_cnt    [2];
    int            en_wide   [2];
    int            done_cnt  [2];
    int            done_cyc  [2];
    int            stop_bad  [2];
    int            rx_n      [2];
    bit            rx_act    [2];
    bit            en_prev   [2];
    logic          busy_done [2];
    logic [7:0]    rx_b      [2];
    logic [7:0]    rx_q      [2][$];
    int            fstart    [2][$];
    logic [AW-1:0] addr_q    [2][$];
    logic [3:0]    idx_q     [2][$];

    // Line decoder and read-port recorder, sampled on the falling edge
    initial begin
        for (int k = 0; k < 2; k++) begin
            en_cnt[k] = 0; en_wide[k] = 0; done_cnt[k] = 0; done_cyc[k] = 0;
            stop_bad[k] = 0; rx_n[k] = 0; rx_act[k] = 1'b0; en_prev[k] = 1'b0;
            busy_done[k] = 1'b0; rx_b[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    rx_act[k] = 1'b0;
                end else begin
                    if (en_s[k]) begin
                        en_cnt[k] = en_cnt[k] + 1;
                        addr_q[k].push_back(addr_s[k]);
                        if (en_prev[k]) en_wide[k] = en_wide[k] + 1;
                    end
                    if (done_s[k]) begin
                        done_cnt[k]  = done_cnt[k] + 1;
                        done_cyc[k]  = cyc;
                        busy_done[k] = busy_s[k];
                    end
                    if (!rx_act[k]) begin
                        if (!line_s[k]) begin
                            rx_act[k] = 1'b1;
                            rx_n[k]   = 0;
                            fstart[k].push_back(cyc);
                        end
                    end else begin
                        rx_n[k] = rx_n[k] + 1;
                        if (rx_n[k] >= 6 && rx_n[k] <= 34 && ((rx_n[k] - 2) % 4) == 0)
                            rx_b[k][(rx_n[k] - 6) / 4] = line_s[k];
                        if (rx_n[k] == 20) idx_q[k].push_back(idx_s[k]);
                        if (rx_n[k] == 38) begin
                            if (!line_s[k]) stop_bad[k] = stop_bad[k] + 1;
                            rx_q[k].push_back(rx_b[k]);
                            rx_act[k] = 1'b0;
                        end
                    end
                end
                en_prev[k] = en_s[k];
            end
        end
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s[%0d] observed 0x%0h expected 0x%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic set_start(input int k, input logic v);
        if (k == 0) if0.start = v;
        else        if1.start = v;
    endtask

    task automatic clear_mon(input int k);
        rx_q[k].delete(); fstart[k].delete(); addr_q[k].delete(); idx_q[k].delete();
        en_cnt[k] = 0; en_wide[k] = 0; done_cnt[k] = 0; stop_bad[k] = 0;
    endtask

    // Full dump: returns in the cycle done is high
    task automatic run_dump(input int k, input int n, input int base, input bit inj);
        int         acc;
        int         lat;
        int         exp_lat;
        int         a;
        bit         injd;
        logic [7:0] eb;
        logic [7:0] sum;
        clear_mon(k);
        set_start(k, 1'b1);
        step();
        set_start(k, 1'b0);
        acc = cyc;
        chk("busy_after_start", k, 32'(busy_s[k]), 32'd1);
        exp_lat = n * BYTE_CYC + CSUM_FRAMES * CSUM_EXTRA;
        injd = 1'b0;
        for (int t = 0; t < exp_lat + 20 && done_cnt[k] == 0; t++) begin
            if (inj && !injd && fstart[k].size() == 3) begin
                set_start(k, 1'b1);
                injd = 1'b1;
            end else begin
                set_start(k, 1'b0);
            end
            step();
        end
        set_start(k, 1'b0);
        lat = done_cyc[k] - acc;
        chk("done_seen", k, 32'(done_cnt[k]), 32'd1);
        chk("done_latency_in_window", lat, 32'(lat >= exp_lat - 1 && lat <= exp_lat + 1), 32'd1);
        chk("busy_at_done", k, 32'(busy_done[k]), 32'd0);
        chk("frames", k, 32'(rx_q[k].size()), 32'(n + CSUM_FRAMES));
        chk("mem_en_pulses", k, 32'(en_cnt[k]), 32'(n));
        chk("mem_en_wide", k, 32'(en_wide[k]), 32'd0);
        chk("stop_bits_low", k, 32'(stop_bad[k]), 32'd0);
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            a   = (base + i) % 8192;
            eb  = mem[a];
            sum = sum + eb;
            chk("raddr", i, (i < addr_q[k].size()) ? 32'(addr_q[k][i]) : 32'hFFFF_FFFF, 32'(a));
            chk("byte", i, (i < rx_q[k].size()) ? 32'(rx_q[k][i]) : 32'hFFFF_FFFF, 32'(eb));
            chk("byte_idx", i, (i < idx_q[k].size()) ? 32'(idx_q[k][i]) : 32'hFFFF_FFFF, 32'(i));
            if (i > 0 && i < fstart[k].size())
                chk("frame_spacing", i, 32'(fstart[k][i] - fstart[k][i-1]), 32'(BYTE_CYC));
        end
`ifdef RESULT_CHECKSUM_EN
        chk("csum_byte", n, (n < rx_q[k].size()) ? 32'(rx_q[k][n]) : 32'hFFFF_FFFF, 32'(sum));
        chk("csum_idx", n, (n < idx_q[k].size()) ? 32'(idx_q[k][n]) : 32'hFFFF_FFFF, 32'(n));
`endif
    endtask

    initial begin
        bit found;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i + 1] = 8'(1 << i);
        mem[8190] = 8'hA5;
        mem[8191] = 8'h5A;
        mem[0]    = 8'h3C;

        step(); step(); step();
        chk("rst_mem_en", 0, 32'(if0.mem_en), 32'd0);
        chk("rst_raddr", 0, 32'(if0.mem_raddr), 32'd1);
        chk("rst_raddr", 1, 32'(if1.mem_raddr), 32'd8190);
        chk("rst_uart_tx", 0, 32'(if0.uart_tx), 32'd1);
        chk("rst_busy", 0, 32'(if0.busy), 32'd0);
        chk("rst_done", 0, 32'(if0.done), 32'd0);
        chk("rst_byte_idx", 0, 32'(if0.byte_idx), 32'd0);
        rst = 1'b0;
        step(); step();

        // Dump with a dropped start during frame 3
        run_dump(0, 8, 1, 1'b1);
        // Start during the done cycle is ignored
        set_start(0, 1'b1);
        step();
        set_start(0, 1'b0);
        step();
        chk("start_in_done_ignored", 0, 32'(if0.busy), 32'd0);
        chk("done_once", 0, 32'(done_cnt[0]), 32'd1);
        chk("raddr_back_to_base", 0, 32'(if0.mem_raddr), 32'd1);

        run_dump(0, 8, 1, 1'b0);

        // Start one cycle after done, then reset in data bit 4 of frame 2
        clear_mon(0);
        step();
        set_start(0, 1'b1);
        step();
        set_start(0, 1'b0);
        chk("busy_restart", 0, 32'(if0.busy), 32'd1);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            step();
            if (fstart[0].size() >= 2 && cyc >= fstart[0][1] + 22) found = 1'b1;
        end
        chk("reach_frame2_bit4", 0, 32'(found), 32'd1);
        chk("line_low_before_rst", 0, 32'(if0.uart_tx), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_line_high", 0, 32'(if0.uart_tx), 32'd1);
        chk("rst_busy_low", 0, 32'(if0.busy), 32'd0);
        chk("rst_raddr_base", 0, 32'(if0.mem_raddr), 32'd1);
        chk("rst_idx_zero", 0, 32'(if0.byte_idx), 32'd0);
        step(); step();
        rst = 1'b0;
        step(); step();

        run_dump(0, 8, 1, 1'b0);
        step(); step();

        // Address wrap: 8190, 8191, 0, 1
        run_dump(1, 4, 8190, 1'b0);
        step(); step();

`ifdef RESULT_CHECKSUM_EN
        for (int i = 1; i <= 8; i++) mem[i] = 8'hFF;
        step();
        run_dump(0, 8, 1, 1'b0);
        chk("csum_ff", 8, (rx_q[0].size() > 8) ? 32'(rx_q[0][8]) : 32'hFFFF_FFFF, 32'h0000_00F8);
        step(); step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/puf_result_reader.md
Name: puf_result_reader

Overview:
Reader end of the NIST pass-count result memory. On a start pulse it reads NUM_RESULTS consecutive bytes from the result BRAM through its synchronous read port, starting at BASE_ADDR. It then serialises each byte on a UART line (8N1, LSB first) so the host can collect the per-test pass counts. It sits between the result BRAM read port and the board UART pin.

Parameters:
ADDR_WIDTH, 13, result memory address width
DATA_WIDTH, 8, result memory data width; also the UART payload width
NUM_RESULTS, 8, number of result bytes read per dump (one per NIST test)
BASE_ADDR, 1, address of the first result byte
CLKS_PER_BIT, 868, clk cycles per UART bit (115200 baud at 100 MHz); minimum 2

Ports:
clk  input  1  single system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse requesting a dump; ignored while busy
mem_en  output  1  read enable to the result BRAM
mem_raddr  output  ADDR_WIDTH  read address to the result BRAM
mem_rdata  input  DATA_WIDTH  BRAM read data, valid exactly one cycle after mem_en
uart_tx  output  1  serial line; idles high
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the last stop bit completes
byte_idx  output  4  index of the byte currently being sent (0..NUM_RESULTS-1)

Behaviour:
- Reset values (asynchronous, immediate):
  - mem_en=0, mem_raddr=BASE_ADDR, uart_tx=1, busy=0, done=0, byte_idx=0.
  - FSM goes to IDLE; the UART sub-module goes to idle.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, TX_REQ, TX_WAIT, NEXT, DONE.
- IDLE: when start=1, set mem_raddr=BASE_ADDR, byte_idx=0, busy=1, and go to RD_ISSUE.
- RD_ISSUE: mem_en=1 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: capture mem_rdata into a holding register, then go to TX_REQ.
  - Read latency is fixed at 1 cycle; no wait states are supported.
- TX_REQ: assert tx_valid to the sub-module with the held byte.
  - Wait for the handshake (tx_valid & tx_ready), then go to TX_WAIT.
- TX_WAIT: remain until the sub-module reports frame complete (tx_ready high again), then go to NEXT.
- NEXT:
  - If byte_idx == NUM_RESULTS-1, go to DONE.
  - Otherwise increment byte_idx, increment mem_raddr (modulo 2^ADDR_WIDTH, wraps silently), and go to RD_ISSUE.
- DONE: done=1 for one cycle, busy=0, mem_raddr returns to BASE_ADDR, go to IDLE.
- UART frame:
  - Start bit (0), then 8 data bits LSB first, then stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
  - uart_tx stays high between frames for at least 1 cycle.
- start pulses while busy=1 are dropped; no queuing.
- start in the same cycle as DONE is ignored; a dump needs start while in IDLE.
- rst asserted mid-frame:
  - uart_tx goes high immediately and the frame is truncated.
  - The next dump restarts from BASE_ADDR.
- mem_en is never asserted outside RD_ISSUE.
- Total dump latency (start to done) = NUM_RESULTS*(10*CLKS_PER_BIT + 5) ± 1 cycles. The bench checks done within this window.

Optional Feature:
RESULT_CHECKSUM_EN
- Defined:
  - After the last result byte, one extra frame is sent carrying the 8-bit modulo-256 sum of all NUM_RESULTS bytes sent.
  - byte_idx reads NUM_RESULTS during that frame.
  - done pulses after the checksum stop bit.
  - The accumulator clears on accepted start and on reset.
- Undefined: no checksum logic and no extra frame; behaviour as above.

Decomposition:
- Shared package puf_result_pkg holds:
  - the FSM state enumeration (3-bit encoding);
  - constants DEFAULT_BASE_ADDR=1 and NUM_NIST_TESTS=8;
  - UART constants FRAME_BITS=10, START_BIT=0, STOP_BIT=1.
- One sub-module, uart_tx_byte:
  - parameters CLKS_PER_BIT and DATA_WIDTH;
  - ports clk, rst, tx_valid, tx_data, tx_ready, tx_line;
  - contains the bit-time counter and shift register;
  - the top holds only the read/sequence FSM.

Test Plan:
- CLKS_PER_BIT=4; BRAM addr 1..8 = 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80; pulse start -> 8 frames decoded in that order, LSB first, each 40 cycles; done pulses once; busy low afterwards.
- Check reads -> mem_raddr sequence 1..8 observed only on mem_en cycles; 8 mem_en pulses total, each 1 cycle wide.
- Pulse start again at the 3rd frame -> no change to sequence, still 8 frames; a start one cycle after done -> second full dump.
- Assert rst during bit 4 of frame 2 -> uart_tx=1 the same cycle, busy=0; a new start -> dump begins at addr 1 with 0x01.
- Set BASE_ADDR=8190, NUM_RESULTS=4 -> addresses 8190, 8191, 0, 1 read.
- With RESULT_CHECKSUM_EN, data 0xFF ×8 -> 9th frame = 0xF8, byte_idx=8 during it, done after the 9th stop bit.
